// File: rtl/rdc_event_logger.sv
// Logs the first rising of each per-core RDC interrupt flag as a timestamped
// record in a small FIFO; one record is accepted per cycle, lowest index first.
module rdc_event_logger #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int N_CORES     = 2,
   parameter  int CORE_EVENTS = 4,
   parameter  int FIFO_DEPTH  = 4,
   localparam int NS = N_CORES * CORE_EVENTS,
   localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1,
   localparam int EW = (CORE_EVENTS > 1) ? $clog2(CORE_EVENTS) : 1,
   localparam int PW = $clog2(FIFO_DEPTH),
   localparam int LW = PW + 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  enable_i,
   input  logic [NS-1:0]         irq_vector_i,
   output logic                  rec_valid_o,
   input  logic                  rec_ready_i,
   output logic [CW-1:0]         rec_core_o,
   output logic [EW-1:0]         rec_event_o,
   output logic [DATA_WIDTH-1:0] rec_time_o,
   output logic [LW-1:0]         level_o,
   output logic                  stall_o
);

   logic [DATA_WIDTH-1:0] ts_q, ts_d;
   logic [NS-1:0]         seen_q, seen_d;
   logic [NS-1:0]         pending_q, pending_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  stall_q, stall_d;
   logic [CW-1:0]         core_mem_q  [FIFO_DEPTH];
   logic [CW-1:0]         core_mem_d  [FIFO_DEPTH];
   logic [EW-1:0]         event_mem_q [FIFO_DEPTH];
   logic [EW-1:0]         event_mem_d [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] time_mem_q  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] time_mem_d  [FIFO_DEPTH];

   logic [NS-1:0] cand;
   logic [NS-1:0] sel_onehot;
   logic [CW-1:0] sel_core;
   logic [EW-1:0] sel_event;
   logic          full;
   logic          push;
   logic          pop;

   // Descending scan so the lowest-index candidate is the last one written.
   always_comb begin
      cand       = pending_q | (irq_vector_i & ~seen_q);
      sel_onehot = '0;
      sel_core   = '0;
      sel_event  = '0;
      for (int c = N_CORES - 1; c >= 0; c--) begin
         for (int e = CORE_EVENTS - 1; e >= 0; e--) begin
            if (cand[c*CORE_EVENTS+e]) begin
               sel_onehot                  = '0;
               sel_onehot[c*CORE_EVENTS+e] = 1'b1;
               sel_core                    = CW'(c);
               sel_event                   = EW'(e);
            end
         end
      end
   end

   assign full = (level_q == LW'(FIFO_DEPTH));
   assign push = enable_i && (|cand) && !full;
   assign pop  = enable_i && (level_q != '0) && rec_ready_i;

   // Disabled cycles fall through to the cleared defaults; record storage is kept.
   always_comb begin
      ts_d        = '0;
      seen_d      = '0;
      pending_d   = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      stall_d     = 1'b0;
      core_mem_d  = core_mem_q;
      event_mem_d = event_mem_q;
      time_mem_d  = time_mem_q;
      if (enable_i) begin
         ts_d      = ts_q + 1'b1;
         seen_d    = seen_q | irq_vector_i;
         pending_d = push ? (cand & ~sel_onehot) : cand;
         stall_d   = stall_q | ((|cand) && full);
         wr_ptr_d  = wr_ptr_q + PW'(push);
         rd_ptr_d  = rd_ptr_q + PW'(pop);
         level_d   = level_q + LW'(push) - LW'(pop);
         if (push) begin
            core_mem_d[wr_ptr_q]  = sel_core;
            event_mem_d[wr_ptr_q] = sel_event;
            time_mem_d[wr_ptr_q]  = ts_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ts_q        <= '0;
         seen_q      <= '0;
         pending_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         stall_q     <= 1'b0;
         core_mem_q  <= '{default: '0};
         event_mem_q <= '{default: '0};
         time_mem_q  <= '{default: '0};
      end else begin
         ts_q        <= ts_d;
         seen_q      <= seen_d;
         pending_q   <= pending_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         stall_q     <= stall_d;
         core_mem_q  <= core_mem_d;
         event_mem_q <= event_mem_d;
         time_mem_q  <= time_mem_d;
      end
   end

   assign rec_valid_o = (level_q != '0);
   assign rec_core_o  = core_mem_q[rd_ptr_q];
   assign rec_event_o = event_mem_q[rd_ptr_q];
   assign rec_time_o  = time_mem_q[rd_ptr_q];
   assign level_o     = level_q;
   assign stall_o     = stall_q;

endmodule

// File: tb/tb_rdc_event_logger.sv
// Directed bench for rdc_event_logger: table of per-cycle vectors plus
// hand-written reset and timestamp-wrap sequences.
module tb_rdc_event_logger;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en, rdy, valid, stall;
   logic [7:0]  irq;
   logic [0:0]  core;
   logic [1:0]  ev;
   logic [31:0] tim;
   logic [2:0]  lvl;

   // narrow-timestamp instance for the wrap case
   logic        en_w, rdy_w, valid_w, stall_w;
   logic [7:0]  irq_w;
   logic [0:0]  core_w;
   logic [1:0]  ev_w;
   logic [3:0]  tim_w;
   logic [2:0]  lvl_w;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rdc_event_logger dut (
      .clk_i(clk), .rstn_i(rstn), .enable_i(en), .irq_vector_i(irq),
      .rec_valid_o(valid), .rec_ready_i(rdy), .rec_core_o(core),
      .rec_event_o(ev), .rec_time_o(tim), .level_o(lvl), .stall_o(stall)
   );

   rdc_event_logger #(.DATA_WIDTH(4)) dut_w (
      .clk_i(clk), .rstn_i(rstn), .enable_i(en_w), .irq_vector_i(irq_w),
      .rec_valid_o(valid_w), .rec_ready_i(rdy_w), .rec_core_o(core_w),
      .rec_event_o(ev_w), .rec_time_o(tim_w), .level_o(lvl_w), .stall_o(stall_w)
   );

   typedef struct {
      logic        en;
      logic [7:0]  irq;
      logic        rdy;
      logic        v;
      logic [0:0]  core;
      logic [1:0]  ev;
      logic [31:0] t;
      logic [2:0]  lvl;
      logic        st;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [0:0] c,
                          input logic [1:0] e, input logic [31:0] t,
                          input logic [2:0] l, input logic s);
      chk({tag, " valid"}, 64'(valid), 64'(v));
      chk({tag, " level"}, 64'(lvl), 64'(l));
      chk({tag, " stall"}, 64'(stall), 64'(s));
      if (v) begin
         chk({tag, " core"},  64'(core), 64'(c));
         chk({tag, " event"}, 64'(ev), 64'(e));
         chk({tag, " time"},  64'(tim), 64'(t));
      end
   endtask

   task automatic step(input logic e, input logic [7:0] i, input logic r);
      en  = e;
      irq = i;
      rdy = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic e, input logic [7:0] i, input logic r, input logic v,
                      input logic [0:0] c, input logic [1:0] ev_x, input logic [31:0] t,
                      input logic [2:0] l, input logic s);
      vec_t x;
      x.en = e; x.irq = i; x.rdy = r; x.v = v; x.core = c;
      x.ev = ev_x; x.t = t; x.lvl = l; x.st = s;
      vecs.push_back(x);
   endtask

   initial begin
      // one logged bit held high, then idle
      for (int k = 0; k < 5; k++) add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      add(1, 8'h40, 1, 1, 1, 2, 5, 1, 0);
      add(1, 8'h40, 1, 0, 0, 0, 0, 0, 0);
      add(1, 8'h40, 1, 0, 0, 0, 0, 0, 0);
      add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      // three simultaneous bits drain one per cycle
      add(1, 8'h89, 1, 1, 0, 0, 10, 1, 0);
      add(1, 8'h89, 1, 1, 0, 3, 11, 1, 0);
      add(1, 8'h89, 1, 1, 1, 3, 12, 1, 0);
      add(1, 8'h89, 1, 0, 0, 0, 0, 0, 0);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      // six bits into a four-deep FIFO with the reader stalled
      add(1, 8'h3F, 0, 1, 0, 0, 0, 1, 0);
      add(1, 8'h3F, 0, 1, 0, 0, 0, 2, 0);
      add(1, 8'h3F, 0, 1, 0, 0, 0, 3, 0);
      add(1, 8'h3F, 0, 1, 0, 0, 0, 4, 0);
      add(1, 8'h3F, 0, 1, 0, 0, 0, 4, 1);
      add(1, 8'h3F, 1, 1, 0, 1, 1, 3, 1);
      add(1, 8'h3F, 1, 1, 0, 2, 2, 3, 1);
      add(1, 8'h3F, 1, 1, 0, 3, 3, 3, 1);
      add(1, 8'h3F, 1, 1, 1, 0, 6, 2, 1);
      add(1, 8'h3F, 1, 1, 1, 1, 7, 1, 1);
      add(1, 8'h3F, 1, 0, 0, 0, 0, 0, 1);
      // flush with records stored, then re-log a held bit
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      add(1, 8'h04, 0, 1, 0, 2, 0, 1, 0);
      add(1, 8'h14, 0, 1, 0, 2, 0, 2, 0);
      add(0, 8'h14, 1, 0, 0, 0, 0, 0, 0);
      add(1, 8'h04, 0, 1, 0, 2, 0, 1, 0);
      add(1, 8'h04, 1, 0, 0, 0, 0, 0, 0);

      rstn = 1'b0; en = 1'b0; irq = '0; rdy = 1'b0;
      en_w = 1'b0; irq_w = '0; rdy_w = 1'b0;

      repeat (3) begin
         @(negedge clk);
         en  = 1'b1;
         irq = 8'($urandom_range(0, 255));
         rdy = 1'($urandom_range(0, 1));
         #1;
         chk_out("in_reset", 0, 0, 0, 0, 0, 0);
         chk("in_reset core", 64'(core), 64'd0);
         chk("in_reset event", 64'(ev), 64'd0);
         chk("in_reset time", 64'(tim), 64'd0);
      end
      @(negedge clk);
      en = 1'b0; irq = '0; rdy = 1'b0;
      rstn = 1'b1;

      foreach (vecs[k]) begin
         step(vecs[k].en, vecs[k].irq, vecs[k].rdy);
         chk_out($sformatf("vec%0d", k), vecs[k].v, vecs[k].core, vecs[k].ev,
                 vecs[k].t, vecs[k].lvl, vecs[k].st);
      end

      // reset in the middle of operation drops stored records
      step(1, 8'h03, 0);
      chk_out("pre_rst1", 1, 0, 0, 2, 1, 0);
      step(1, 8'h03, 0);
      chk_out("pre_rst2", 1, 0, 0, 2, 2, 0);
      en = 1'b0; irq = '0;
      #2 rstn = 1'b0;
      #1;
      chk_out("mid_rst", 0, 0, 0, 0, 0, 0);
      chk("mid_rst time", 64'(tim), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      step(1, 8'h02, 0);
      chk_out("post_rst", 1, 0, 1, 0, 1, 0);
      en = 1'b0; irq = '0;

      // timestamp wrap on the 4-bit instance
      en_w = 1'b1; irq_w = '0; rdy_w = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("wrap idle level", 64'(lvl_w), 64'd0);
      irq_w = 8'h02;
      @(posedge clk);
      @(negedge clk);
      chk("wrap1 valid", 64'(valid_w), 64'd1);
      chk("wrap1 event", 64'(ev_w), 64'd1);
      chk("wrap1 time", 64'(tim_w), 64'd15);
      irq_w = 8'h0A;
      @(posedge clk);
      @(negedge clk);
      chk("wrap2 level", 64'(lvl_w), 64'd1);
      chk("wrap2 event", 64'(ev_w), 64'd3);
      chk("wrap2 time", 64'(tim_w), 64'd0);
      chk("wrap2 stall", 64'(stall_w), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rdc_event_logger.md
RDC_EVENT_LOGGER -- requirements
Module: rdc_event_logger

Interface
REQ-001 Parameter DATA_WIDTH, default 32: timestamp width.
REQ-002 Parameter N_CORES, default 2: monitored cores.
REQ-003 Parameter CORE_EVENTS, default 4: events per core.
REQ-004 Parameter FIFO_DEPTH, default 4: record slots; power of 2, >=2.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 enable_i  in  1  active-high; low = synchronous flush.
REQ-008 irq_vector_i  in  N_CORES*CORE_EVENTS  per-signal RDC interrupt flags; bit index = core*CORE_EVENTS+event.
REQ-009 rec_valid_o  out  1  FIFO head record valid.
REQ-010 rec_ready_i  in  1  reader accepts head record.
REQ-011 rec_core_o  out  max(1,clog2(N_CORES))  core index of head record.
REQ-012 rec_event_o  out  max(1,clog2(CORE_EVENTS))  event index of head record.
REQ-013 rec_time_o  out  DATA_WIDTH  timestamp of head record.
REQ-014 level_o  out  clog2(FIFO_DEPTH)+1  records stored.
REQ-015 stall_o  out  1  sticky: a candidate was blocked by full FIFO.

Function
REQ-016 Timestamp counter: +1 every enabled cycle; wraps 2^DATA_WIDTH-1 -> 0; cleared to 0 while enable_i low.
REQ-017 seen_q (one bit per signal): set when irq_vector_i bit high while enabled; never cleared except by disable/reset.
REQ-018 Candidate set each cycle = pending_q | (irq_vector_i & ~seen_q).
REQ-019 At most one push per cycle: lowest-index candidate, only if FIFO not full at cycle start; pushed bit removed from pending_q.
REQ-020 Candidates not pushed are held in pending_q; none is ever lost or duplicated.
REQ-021 Each signal is logged at most once per enable period; holding a bit high produces no further records.
REQ-022 Record = {core = idx/CORE_EVENTS, event = idx%CORE_EVENTS, time = timestamp value in the push cycle}.
REQ-023 Latency: bit first high in cycle t with FIFO non-full and no lower candidate -> rec_valid_o high in cycle t+1, rec_time_o = timestamp of cycle t.
REQ-024 Pop when rec_valid_o & rec_ready_i; FIFO order strictly first-in first-out.
REQ-025 rec_core_o/rec_event_o/rec_time_o stable while rec_valid_o high and rec_ready_i low.
REQ-026 Push and pop in same cycle: both performed, level_o unchanged.
REQ-027 Full FIFO: no push even if a pop occurs that cycle; push retried next cycle.
REQ-028 stall_o set when candidate set is non-zero and FIFO full; cleared only by disable/reset.
REQ-029 rec_valid_o = (level_o != 0); head fields are don't-care when rec_valid_o low.
REQ-030 enable_i low: next edge empties FIFO, clears seen_q, pending_q, timestamp, stall_o; rec_ready_i ignored.

Reset
REQ-031 rstn_i low asynchronously clears: rec_valid_o=0, level_o=0, stall_o=0, rec_core_o=0, rec_event_o=0, rec_time_o=0, timestamp=0, seen_q=0, pending_q=0.
REQ-032 Reset asserted mid-operation discards all stored and pending records; first enabled cycle after release has timestamp 0.

Verification (N_CORES=2, CORE_EVENTS=4, FIFO_DEPTH=4, DATA_WIDTH=32)
REQ-033 Reset pulse, any inputs -> all outputs 0 during and after reset until an event is logged.
REQ-034 Enable; bit 6 asserted in cycle with timestamp 5, held high, rec_ready_i=1 -> one record {core 1, event 2, time 5} next cycle; no further records.
REQ-035 Bits 0,3,7 asserted together at timestamp 10, rec_ready_i=1 -> records idx 0,3,7 on consecutive cycles with times 10,11,12.
REQ-036 rec_ready_i=0; bits 0-5 asserted at once -> level_o=4, stall_o=1, records 0-3 held; pops then deliver 4 and 5, no loss, stall_o stays 1.
REQ-037 Two records stored; enable_i low one cycle -> level_o=0, rec_valid_o=0 next cycle; re-enable, bit 2 still high -> logged again with time 0.
REQ-038 Timestamp at 2^32-1 with bit 1 rising -> record time 2^32-1; next push shows time 0 (wrap).
